// File: rtl/clk_div_prog_pkg.sv
// clk_div_prog_pkg: shared state encoding and divisor constants for the programmable divider
package clk_div_prog_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_e;
  localparam int MIN_DIV = 2;
  localparam int LEGACY_DIV = 128;
endpackage

// File: rtl/clk_div_prog_div_period_cnt.sv
// div_period_cnt: period counter with the rise-point and period-boundary compares
module div_period_cnt
  import clk_div_prog_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [CNT_W-1:0] act_div,
  output logic             rise_hit,
  output logic             boundary
);
  logic [CNT_W-1:0] cnt_q, cnt_d, lo_len;
  assign lo_len   = act_div - (act_div >> 1);
  assign rise_hit = run && cnt_q == lo_len - CNT_W'(1);
  assign boundary = run && cnt_q == act_div - CNT_W'(1);
  // advance through the period, wrap at the boundary, park at 0 while idle
  always_comb cnt_d = (!run || boundary) ? '0 : cnt_q + CNT_W'(1);
  // counter register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock/strobe divider with boundary-synchronous ratio change
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEF_DIV    = LEGACY_DIV,
  parameter bit AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_o,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             div_pend,
  output logic             div_err,
  output logic             running
);
  localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
  localparam state_e RST_STATE = AUTO_START ? ST_RUN : ST_IDLE;
  state_e state_q, state_d;
  logic [CNT_W-1:0] act_div_q, act_div_d, pend_q, pend_d, div_clamp;
  logic div_pend_q, div_pend_d, div_err_q, div_err_d;
  logic clk_o_q, clk_o_d, rise_stb_q, rise_stb_d, fall_stb_q, fall_stb_d;
  logic run, rise_hit, boundary;
  assign run       = state_q != ST_IDLE;
  assign div_clamp = div_in < MIN_DIV_W ? MIN_DIV_W : div_in;
  div_period_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .act_div (act_div_q),
    .rise_hit(rise_hit),
    .boundary(boundary)
  );
  // STOP only falls back to IDLE at a period boundary so clk_o is never truncated
  always_comb begin
    state_d = state_q == ST_IDLE ? (en ? ST_RUN : ST_IDLE)
            : en ? ST_RUN
            : (state_q == ST_STOP && boundary) ? ST_IDLE : ST_STOP;
  end
  // divisor staging: direct when idle or at a boundary, otherwise held pending until one
  always_comb begin
    act_div_d  = act_div_q;
    pend_d     = pend_q;
    div_pend_d = div_pend_q;
    if (div_load && (!run || boundary)) begin
      act_div_d  = div_clamp;
      div_pend_d = 1'b0;
    end else if (div_load) begin
      pend_d     = div_clamp;
      div_pend_d = 1'b1;
    end else if (boundary && div_pend_q) begin
      act_div_d  = pend_q;
      div_pend_d = 1'b0;
    end
    div_err_d = div_load && div_in < MIN_DIV_W;
  end
  // divided clock and its edge strobes
  always_comb begin
    clk_o_d    = (!run || boundary) ? 1'b0 : rise_hit ? 1'b1 : clk_o_q;
    rise_stb_d = rise_hit;
    fall_stb_d = boundary;
  end
  // state and output registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= RST_STATE;
      act_div_q  <= DEF_DIV_W;
      pend_q     <= DEF_DIV_W;
      div_pend_q <= 1'b0;
      div_err_q  <= 1'b0;
      clk_o_q    <= 1'b0;
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_div_q  <= act_div_d;
      pend_q     <= pend_d;
      div_pend_q <= div_pend_d;
      div_err_q  <= div_err_d;
      clk_o_q    <= clk_o_d;
      rise_stb_q <= rise_stb_d;
      fall_stb_q <= fall_stb_d;
    end
  assign clk_o    = clk_o_q;
  assign rise_stb = rise_stb_q;
  assign fall_stb = fall_stb_q;
  assign div_pend = div_pend_q;
  assign div_err  = div_err_q;
  assign running  = run;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scoreboard bench against a waveform-queue reference model
module tb_clk_div_prog;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b1;
  logic div_load = 1'b0;
  logic [15:0] div_in = '0;
  logic clk_o, rise_stb, fall_stb, div_pend, div_err, running;
  int tests = 0;
  int fails = 0;

  clk_div_prog #(.CNT_W(16), .DEF_DIV(128), .AUTO_START(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .div_load(div_load),
    .div_in  (div_in),
    .clk_o   (clk_o),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb),
    .div_pend(div_pend),
    .div_err (div_err),
    .running (running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic clk_o, rise, fall, pend, err, running;
  } exp_t;
  exp_t sbq[$];
  bit   wave[$];
  int   m_state = 1;
  int   act = 128;
  int   pend = 128;
  bit   pendf = 0;
  bit   prev_clk = 0;

  // reference model: each period is expanded into its full clk_o sample list when it starts
  always @(posedge clk or negedge reset_n) begin : model
    int cl;
    bit v, bnd, ld;
    exp_t e;
    if (!reset_n) begin
      m_state = 1; act = 128; pend = 128; pendf = 0; prev_clk = 0;
      wave.delete(); sbq.delete();
    end else begin
      ld = div_load;
      cl = div_in < 2 ? 2 : int'(div_in);
      v = 0; bnd = 0;
      if (m_state != 0) begin
        if (wave.size() == 0)
          for (int i = 0; i < act; i++) wave.push_back(i >= act - act / 2 - 1 && i < act - 1);
        v = wave.pop_front();
        bnd = wave.size() == 0;
      end
      if (ld && (m_state == 0 || bnd)) begin act = cl; pendf = 0; end
      else if (ld) begin pend = cl; pendf = 1; end
      else if (bnd && pendf) begin act = pend; pendf = 0; end
      m_state = m_state == 0 ? (en ? 1 : 0) : en ? 1 : (m_state == 2 && bnd) ? 0 : 2;
      e = '{v, v && !prev_clk, bnd, pendf, ld && div_in < 2, m_state != 0};
      prev_clk = v;
      sbq.push_back(e);
    end
  end

  // monitor: pops one expected response per registered DUT output update
  always @(posedge clk) begin : monitor
    exp_t e, a;
    #1;
    if (reset_n && sbq.size() > 0) begin
      e = sbq.pop_front();
      a = '{clk_o, rise_stb, fall_stb, div_pend, div_err, running};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs t=%0t got clk_o=%b rise=%b fall=%b pend=%b err=%b run=%b expected clk_o=%b rise=%b fall=%b pend=%b err=%b run=%b",
                 $time, a.clk_o, a.rise, a.fall, a.pend, a.err, a.running,
                 e.clk_o, e.rise, e.fall, e.pend, e.err, e.running);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int v);
    div_load = 1'b1;
    div_in = 16'(v);
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic wait_bnd_next();
    int n = 0;
    while (wave.size() != 1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL boundary_wait timed out got wave=%0d expected 1", wave.size());
    end
  endtask

  task automatic wait_high();
    int n = 0;
    while (!prev_clk && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL high_wait timed out got clk_o=%b expected 1", prev_clk);
    end
  endtask

  task automatic check(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %b expected %b", name, got, want);
    end
  endtask

  initial begin
    cycles(3);
    check("reset_clk_o", clk_o, 1'b0);
    check("reset_rise", rise_stb, 1'b0);
    check("reset_fall", fall_stb, 1'b0);
    check("reset_pend", div_pend, 1'b0);
    check("reset_err", div_err, 1'b0);
    check("reset_running", running, 1'b1);
    reset_n = 1'b1;
    cycles(1300);
    load(8);
    cycles(40);
    wait_bnd_next();
    cycles(3);
    load(5);
    cycles(30);
    load(6);
    load(10);
    cycles(2);
    wait_bnd_next();
    load(7);
    cycles(40);
    load(0);
    cycles(20);
    load(1);
    cycles(20);
    load(8);
    cycles(20);
    wait_high();
    en = 1'b0;
    cycles(30);
    en = 1'b1;
    cycles(20);
    wait_high();
    en = 1'b0;
    cycles(2);
    en = 1'b1;
    cycles(30);
    load(20);
    cycles(25);
    wait_high();
    load(30);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_clk_o", clk_o, 1'b0);
    check("async_pend", div_pend, 1'b0);
    check("async_running", running, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(300);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      div_load = $urandom_range(0, 24) == 0;
      div_in = 16'($urandom_range(0, 12));
      @(negedge clk);
    end
    div_load = 1'b0;
    en = 1'b1;
    cycles(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
